// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and Gray/binary helpers
// used by both the read and write pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_LEN = 8;

  // Wide enough for any pointer width; callers cast to their own width.
  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
  parameter int W = 9
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/rptr_ctrl.sv
// Read-domain pointer/flag controller of the async FIFO.
// Optional sticky underflow flag enabled by defining RPTR_UNDERFLOW_ERR_EN.
module rptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_LEN  = FIFO_ADDR_LEN,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rincr_i,
  input  logic [ADDR_LEN:0]   w2rptr_sync_i,
  output logic [ADDR_LEN-1:0] fifo_raddr_o,
  output logic [ADDR_LEN:0]   rptr_o,
  output logic                rempty_o,
  output logic                ralmost_empty_o,
  output logic [ADDR_LEN:0]   rlevel_o
`ifdef RPTR_UNDERFLOW_ERR_EN
  ,
  output logic                runderflow_o
`endif
);

  localparam int PW = ADDR_LEN + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rempty_q, rempty_d;
  logic          ralmost_q, ralmost_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic [PW-1:0] wbin;
  logic          rd_en;

  gray2bin #(.W(PW)) u_wptr_g2b (
    .gray_i (w2rptr_sync_i),
    .bin_o  (wbin)
  );

  // Flags use the post-read pointer so reading the last word sets empty at once.
  always_comb begin
    rd_en     = rincr_i & ~rempty_q;
    rbin_d    = rbin_q + {{ADDR_LEN{1'b0}}, rd_en};
    rptr_d    = PW'(bin2gray(ptr_word_t'(rbin_d)));
    rempty_d  = (rptr_d == w2rptr_sync_i);
    rlevel_d  = wbin - rbin_d;
    ralmost_d = (rlevel_d <= AE_T);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      ralmost_q <= 1'b1;
      rlevel_q  <= '0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rempty_q  <= rempty_d;
      ralmost_q <= ralmost_d;
      rlevel_q  <= rlevel_d;
    end
  end

  assign fifo_raddr_o    = rbin_q[ADDR_LEN-1:0];
  assign rptr_o          = rptr_q;
  assign rempty_o        = rempty_q;
  assign ralmost_empty_o = ralmost_q;
  assign rlevel_o        = rlevel_q;

`ifdef RPTR_UNDERFLOW_ERR_EN
  logic runderflow_q, runderflow_d;

  always_comb begin
    runderflow_d = runderflow_q | (rincr_i & rempty_q);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      runderflow_q <= 1'b0;
    end else begin
      runderflow_q <= runderflow_d;
    end
  end

  assign runderflow_o = runderflow_q;
`endif

endmodule

// File: tb/tb_rptr_ctrl.sv
// Self-checking bench for rptr_ctrl (ADDR_LEN=3, AE_THRESH=2) against an
// occupancy-count model of the FIFO read side.
module tb_rptr_ctrl;

  localparam int AL    = 3;
  localparam int DEPTH = 8;
  localparam int AE    = 2;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rincr_i = 1'b0;
  logic [AL:0]   w2rptr_sync_i = '0;
  logic [AL-1:0] fifo_raddr_o;
  logic [AL:0]   rptr_o;
  logic          rempty_o;
  logic          ralmost_empty_o;
  logic [AL:0]   rlevel_o;
`ifdef RPTR_UNDERFLOW_ERR_EN
  logic          runderflow_o;
`endif

  rptr_ctrl #(.ADDR_LEN(AL), .AE_THRESH(AE)) dut (
    .rclk            (rclk),
    .rrst            (rrst),
    .rincr_i         (rincr_i),
    .w2rptr_sync_i   (w2rptr_sync_i),
    .fifo_raddr_o    (fifo_raddr_o),
    .rptr_o          (rptr_o),
    .rempty_o        (rempty_o),
    .ralmost_empty_o (ralmost_empty_o),
    .rlevel_o        (rlevel_o)
`ifdef RPTR_UNDERFLOW_ERR_EN
    ,
    .runderflow_o    (runderflow_o)
`endif
  );

  always #5 rclk = ~rclk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: total words written (visible) and total words read, as plain integers.
  int wcnt   = 0;
  int rd_cnt = 0;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray_of(input int v);
    int b;
    b = v % (2 * DEPTH);
    return b ^ (b >> 1);
  endfunction

  task automatic set_wcnt(input int v);
    wcnt = v;
    w2rptr_sync_i = (AL+1)'(gray_of(v));
  endtask

  task automatic model_reset();
    rd_cnt  = 0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    set_wcnt(0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  int'(fifo_raddr_o), 0);
    check({tag, "_rptr"},  int'(rptr_o), 0);
    check({tag, "_empty"}, int'(rempty_o), 1);
    check({tag, "_ae"},    int'(ralmost_empty_o), 1);
    check({tag, "_level"}, int'(rlevel_o), 0);
`ifdef RPTR_UNDERFLOW_ERR_EN
    check({tag, "_uf"},    int'(runderflow_o), 0);
`endif
  endtask

  // One rclk edge: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    int lvl;
    @(posedge rclk);
    if (rincr_i && m_empty) m_uf = 1'b1;
    if (rincr_i && !m_empty) rd_cnt++;
    lvl     = wcnt - rd_cnt;
    m_empty = (lvl == 0);
    #1;
    check({tag, "_level"}, int'(rlevel_o), lvl);
    check({tag, "_empty"}, int'(rempty_o), int'(m_empty));
    check({tag, "_ae"},    int'(ralmost_empty_o), int'(lvl <= AE));
    check({tag, "_addr"},  int'(fifo_raddr_o), rd_cnt % DEPTH);
    check({tag, "_rptr"},  int'(rptr_o), gray_of(rd_cnt));
`ifdef RPTR_UNDERFLOW_ERR_EN
    check({tag, "_uf"},    int'(runderflow_o), int'(m_uf));
`endif
  endtask

  task automatic mid_reset(input string tag);
    @(negedge rclk);
    #2 rrst = 1'b1;
    #1;
    check_reset_vals(tag);
    rincr_i = 1'b0;
    model_reset();
    @(posedge rclk);
    #1 rrst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge rclk);
    #1 rrst = 1'b0;
    check_reset_vals("rst");

    // Fill to 4 then drain.
    set_wcnt(4);
    step("fill");
    check("fill_level4", int'(rlevel_o), 4);
    rincr_i = 1'b1;
    repeat (4) step("drain");
    rincr_i = 1'b0;
    check("drain_rptr", int'(rptr_o), 6);
    check("drain_empty", int'(rempty_o), 1);

    // Reads while empty are dropped.
    rincr_i = 1'b1;
    repeat (3) step("uflow");
    check("uflow_addr", int'(fifo_raddr_o), 4);
`ifdef RPTR_UNDERFLOW_ERR_EN
    rincr_i = 1'b0;
    step("uf_sticky");
    check("uf_sticky", int'(runderflow_o), 1);
`endif

    // Wrap: writer advances one per cycle, reader reads every cycle.
    mid_reset("rst2");
    rincr_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      set_wcnt(i);
      step("wrap");
    end
    repeat (3) step("wrap_tail");
    rincr_i = 1'b0;
    check("wrap_rptr", int'(rptr_o), 0);

    // Full level, then read in the same cycle as another pointer step.
    mid_reset("rst3");
    set_wcnt(8);
    step("full");
    check("full_level", int'(rlevel_o), 8);
    rincr_i = 1'b1;
    step("full_rd");
    check("full_rd_level", int'(rlevel_o), 7);
    set_wcnt(9);
    step("rd_and_wr");
    rincr_i = 1'b0;

    // Random writer (monotonic, never more than DEPTH ahead) vs random reader.
    for (int i = 0; i < 600; i++) begin
      int room, inc;
      room = DEPTH - (wcnt - rd_cnt);
      inc  = (room > 0) ? int'($urandom_range(0, (room < 3) ? room : 3)) : 0;
      set_wcnt(wcnt + inc);
      rincr_i = ($urandom_range(0, 99) < 55);
      step("rand");
      if (i == 300) mid_reset("rst_rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
